// File: rtl/reg_scoreboard_pkg.sv
// Shared widths and counter types for the register-file write scoreboard.
// Pure declarations: no latency, no flow control.
package reg_scoreboard_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_CNT_WIDTH  = 2;

    typedef logic [DEF_CNT_WIDTH-1:0] cnt_t;

    localparam cnt_t CNT_MAX = '1;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue/writeback/operand-query bundle between pipeline control and the scoreboard.
// Wires only: no latency, issue_ready is the sole backpressure signal.
interface reg_scoreboard_if
    import reg_scoreboard_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    localparam int NUM_REGS = 2**ADDR_WIDTH;

    logic                  issue_valid;
    logic [ADDR_WIDTH-1:0] issue_rd;
    logic                  issue_ready;
    logic                  wb_valid;
    logic [ADDR_WIDTH-1:0] wb_rd;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic                  rs1_busy;
    logic                  rs2_busy;
    logic [NUM_REGS-1:0]   busy_vec;
    logic                  underflow_err;

    modport master (
        output issue_valid, issue_rd, wb_valid, wb_rd, rs1, rs2,
        input  issue_ready, rs1_busy, rs2_busy, busy_vec, underflow_err
    );

    modport slave (
        input  issue_valid, issue_rd, wb_valid, wb_rd, rs1, rs2,
        output issue_ready, rs1_busy, rs2_busy, busy_vec, underflow_err
    );

endinterface

// File: rtl/reg_scoreboard_onehot_decoder.sv
// Binary index to one-hot vector, gated by an enable.
// Combinational, zero latency; no flow control.
module onehot_decoder #(
    parameter int WIDTH = 5
) (
    input  logic                  en_i,
    input  logic [WIDTH-1:0]      idx_i,
    output logic [2**WIDTH-1:0]   onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters; busy/hazard view 1 cycle after issue/writeback, queries are combinational.
// Refuses issue (issue_ready=0) to a saturated register unless it retires the same cycle. Macro: SCOREBOARD_WB_BYPASS_EN.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int ZERO_REG   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    reg_scoreboard_if.slave   sb
);

    localparam int                   NUM_REGS = 2**ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CMAX     = '1;
    localparam logic [CNT_WIDTH-1:0] CONE     = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_q [NUM_REGS];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_REGS];
    logic                 err_q;
    logic                 err_d;

    logic [NUM_REGS-1:0] track;
    logic [NUM_REGS-1:0] inc_raw;
    logic [NUM_REGS-1:0] dec_raw;
    logic [NUM_REGS-1:0] inc_oh;
    logic [NUM_REGS-1:0] dec_oh;
    logic [NUM_REGS-1:0] busy;
    logic                rd_zero;
    logic                same_rd;
    logic                issue_ok;
    logic                byp1;
    logic                byp2;

    always_comb begin
        track = '1;
        if (ZERO_REG != 0) begin
            track[0] = 1'b0;
        end
    end

    // A saturated register still accepts an issue when it retires in the same cycle.
    assign rd_zero        = (ZERO_REG != 0) && (sb.issue_rd == '0);
    assign same_rd        = sb.wb_valid && (sb.wb_rd == sb.issue_rd);
    assign sb.issue_ready = rd_zero || (cnt_q[sb.issue_rd] != CMAX) || same_rd;
    assign issue_ok       = sb.issue_valid && sb.issue_ready;

    onehot_decoder #(.WIDTH(ADDR_WIDTH)) u_issue_dec (
        .en_i     (issue_ok),
        .idx_i    (sb.issue_rd),
        .onehot_o (inc_raw)
    );

    onehot_decoder #(.WIDTH(ADDR_WIDTH)) u_wb_dec (
        .en_i     (sb.wb_valid),
        .idx_i    (sb.wb_rd),
        .onehot_o (dec_raw)
    );

    assign inc_oh = inc_raw & track;
    assign dec_oh = dec_raw & track;

    always_comb begin
        err_d = err_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
            busy[i]  = (cnt_q[i] != '0);
            if (inc_oh[i] && !dec_oh[i]) begin
                cnt_d[i] = cnt_q[i] + CONE;
            end else if (dec_oh[i] && !inc_oh[i]) begin
                if (cnt_q[i] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CONE;
                end
            end
        end
    end

`ifdef SCOREBOARD_WB_BYPASS_EN
    // Last pending write retiring now can be forwarded, so the reader need not stall.
    assign byp1 = sb.wb_valid && (sb.wb_rd == sb.rs1) && (cnt_q[sb.rs1] == CONE) && !inc_oh[sb.rs1];
    assign byp2 = sb.wb_valid && (sb.wb_rd == sb.rs2) && (cnt_q[sb.rs2] == CONE) && !inc_oh[sb.rs2];
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign sb.rs1_busy      = busy[sb.rs1] && !byp1;
    assign sb.rs2_busy      = busy[sb.rs2] && !byp2;
    assign sb.busy_vec      = busy & track;
    assign sb.underflow_err = err_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

endmodule
